sbox_swap_ram: RTL and testbench
================================

Name: sbox_swap_ram

Overview:
- Parametrised RC4 state memory (S-box) holding 2**ADDR_W entries.
- Built-in multi-cycle identity-fill sequencer; no single-cycle bulk reset of the array.
- Atomic swap command with valid/ready handshake and pipelined keystream lookup: S[(S[i]+S[j]) mod DEPTH].
- One combinational peek port for j-update arithmetic; NUM_RD registered read ports for key-schedule or debug.
- Sits between the KSA/PRGA controller and the keystream XOR stage.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 8, entry width; must be >= ADDR_W.
- NUM_RD, 4, number of registered read ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  restart identity fill
- init_done  out  1  high when memory is initialised and block is operational
- peek_addr  in  ADDR_W  combinational read address
- peek_data  out  DATA_W  mem[peek_addr], same cycle
- swap_valid  in  1  swap request
- swap_ready  out  1  swap can be accepted
- swap_addr_i  in  ADDR_W  first swap index
- swap_addr_j  in  ADDR_W  second swap index
- ks_valid  out  1  keystream byte valid (1-cycle pulse per swap)
- ks_data  out  DATA_W  keystream byte
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data

Behaviour:
- Reset: asynchronous on rst_n low.
  - init_done=0, swap_ready=0, ks_valid=0, ks_data=0, rd_data=0.
  - FSM goes to INIT with fill counter 0.
  - Array contents are not reset.
- FSM has two states, INIT and READY.
- INIT:
  - One write per cycle: mem[cnt] <= cnt, zero-extended to DATA_W. cnt then increments.
  - After the write with cnt=DEPTH-1, go to READY.
  - Fill takes exactly DEPTH cycles after reset release or init_start.
  - swap_ready=0, ks_valid=0, init_done=0 throughout.
- READY:
  - init_done=1, swap_ready=1.
  - init_start=1 returns the FSM to INIT with cnt=0 on the next edge. Any in-flight ks pipeline entry is squashed, so ks_valid=0.
  - init_start in INIT restarts cnt at 0.
- Swap accept:
  - A swap is accepted in cycle N when swap_valid && swap_ready.
  - On that edge: mem[i] <= old mem[j] and mem[j] <= old mem[i], both from combinational reads in cycle N.
  - If i==j, memory is unchanged.
  - Also on that edge, t <= (old mem[i] + old mem[j]) mod DEPTH, using the low ADDR_W bits of the sum. The sum is swap-invariant.
  - swap_valid while not ready is ignored; no buffering.
- Keystream:
  - Cycle N+1: combinational read mem[t]. This reflects the swap from cycle N and excludes any swap accepted in N+1.
  - The value is registered at the end of N+1, so ks_valid=1 and ks_data are presented in cycle N+2.
  - ks_valid is high for exactly one cycle per accepted swap.
  - Full throughput: one swap per cycle, ks_valid high every cycle for back-to-back swaps.
  - ks_data holds its last value when ks_valid=0.
- peek_data is purely combinational from the current array state, i.e. pre-write in the current cycle.
- Read ports:
  - rd_data for port p is registered every cycle: rd_data[p] <= mem[rd_addr[p]].
  - Read-before-write: a read coinciding with a swap write returns the old value.
  - Latency 1.
  - Valid in any state; contents during INIT are unspecified.
- Address width rule: all addresses are ADDR_W bits; there is no out-of-range case.
- Reset mid-operation (INIT or READY): immediate return to the reset state. The full DEPTH-cycle fill runs after release.

Test Plan:
- Reset release -> init_done rises exactly 256 cycles later. rd_addr ports 0..3 = {0,1,2,3} then give rd_data {0,1,2,3} one cycle later. peek_addr=200 gives peek_data=200.
- Swap i=1, j=5 after init:
  - peek shows S[1]=5 and S[5]=1 the next cycle.
  - t=6; ks_valid pulses two cycles after accept with ks_data=6.
- Swap i=j=7 -> memory unchanged (S[7]=7), t=14, ks_data=14.
- Back-to-back swaps (1,2) then (2,3) on consecutive cycles:
  - ks_valid high two consecutive cycles with ks_data=3, then 4.
  - Final state: S[1]=2, S[2]=3, S[3]=1.
- init_start pulsed the cycle after a swap accept:
  - That swap's ks_valid never asserts.
  - swap_ready=0 for 256 cycles.
  - Afterwards S[1]=1 and S[5]=5 (identity restored).
- rst_n asserted at fill count 100 -> outputs clear immediately. After release, init_done rises 256 cycles later and the memory is full identity.

Source files
------------

// File: rtl/sbox_swap_ram.sv
// sbox_swap_ram -- RC4 state memory (S-box) with identity fill, atomic swap
// and pipelined keystream lookup.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   init_start       restart the identity fill (mem[k] = k for all k)
//   init_done        high once the fill has completed and the block is usable
//   peek_addr/data   combinational read of the current (pre-write) contents
//   swap_valid/ready swap handshake; swap_addr_i / swap_addr_j are the indices
//   ks_valid/data    keystream byte S[(S[i]+S[j]) mod DEPTH], two cycles after
//                    the swap is accepted
//   rd_addr/rd_data  NUM_RD packed registered read ports (latency 1)
module sbox_swap_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int NUM_RD = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       init_start,
   output logic                       init_done,
   input  logic [ADDR_W-1:0]          peek_addr,
   output logic [DATA_W-1:0]          peek_data,
   input  logic                       swap_valid,
   output logic                       swap_ready,
   input  logic [ADDR_W-1:0]          swap_addr_i,
   input  logic [ADDR_W-1:0]          swap_addr_j,
   output logic                       ks_valid,
   output logic [DATA_W-1:0]          ks_data,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_INIT, S_READY} state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          cnt_q, cnt_d;
   logic                       init_done_q, init_done_d;
   logic                       swap_ready_q, swap_ready_d;
   logic [ADDR_W-1:0]          t_q, t_d;
   logic                       t_valid_q, t_valid_d;
   logic                       ks_valid_q, ks_valid_d;
   logic [DATA_W-1:0]          ks_data_q, ks_data_d;
   logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;

   logic [DATA_W-1:0]          mem_i, mem_j, mem_t;
   logic                       swap_acc;
   logic                       fill_we;

   // Combinational reads of the array as it stands before this cycle's writes.
   assign peek_data = mem[peek_addr];
   assign mem_i     = mem[swap_addr_i];
   assign mem_j     = mem[swap_addr_j];
   assign mem_t     = mem[t_q];

   assign swap_acc  = swap_valid && swap_ready_q;
   assign fill_we   = (state_q == S_INIT);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      t_d          = t_q;
      t_valid_d    = 1'b0;
      ks_valid_d   = 1'b0;
      ks_data_d    = ks_data_q;

      case (state_q)
         S_INIT: begin
            if (init_start) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == {ADDR_W{1'b1}}) begin
                  state_d = S_READY;
               end
            end
         end
         default: begin
            if (init_start) begin
               state_d = S_INIT;
               cnt_d   = '0;
            end
         end
      endcase

      // Ready/done are registered copies of the next state so they change
      // on the same edge as the state itself.
      init_done_d  = (state_d == S_READY);
      swap_ready_d = (state_d == S_READY);

      // Sum is swap-invariant, so it can be formed from the pre-swap reads.
      if (swap_acc) begin
         t_d = mem_i[ADDR_W-1:0] + mem_j[ADDR_W-1:0];
      end
      // init_start squashes both pipeline stages so no stale keystream
      // escapes into the fill period.
      t_valid_d  = swap_acc && !init_start;
      ks_valid_d = t_valid_q && !init_start;
      if (ks_valid_d) begin
         ks_data_d = mem_t;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         assign rd_data_d[gi*DATA_W +: DATA_W] = mem[rd_addr[gi*ADDR_W +: ADDR_W]];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         init_done_q  <= 1'b0;
         swap_ready_q <= 1'b0;
         t_q          <= '0;
         t_valid_q    <= 1'b0;
         ks_valid_q   <= 1'b0;
         ks_data_q    <= '0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         init_done_q  <= init_done_d;
         swap_ready_q <= swap_ready_d;
         t_q          <= t_d;
         t_valid_q    <= t_valid_d;
         ks_valid_q   <= ks_valid_d;
         ks_data_q    <= ks_data_d;
         rd_data_q    <= rd_data_d;
      end
   end

   // Array has no reset; the fill sequencer establishes its contents.
   // Swap is only possible in READY, so fill and swap never collide.
   // With i==j both writes carry the same value, leaving memory unchanged.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt_q] <= DATA_W'(cnt_q);
      end
      if (swap_acc) begin
         mem[swap_addr_i] <= mem_j;
         mem[swap_addr_j] <= mem_i;
      end
   end

   assign init_done  = init_done_q;
   assign swap_ready = swap_ready_q;
   assign ks_valid   = ks_valid_q;
   assign ks_data    = ks_data_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_sbox_swap_ram.sv
module tb_sbox_swap_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_start;
   logic        init_done;
   logic [7:0]  peek_addr;
   logic [7:0]  peek_data;
   logic        swap_valid;
   logic        swap_ready;
   logic [7:0]  swap_addr_i;
   logic [7:0]  swap_addr_j;
   logic        ks_valid;
   logic [7:0]  ks_data;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sbox_swap_ram #(.ADDR_W(8), .DATA_W(8), .NUM_RD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .init_start  (init_start),
      .init_done   (init_done),
      .peek_addr   (peek_addr),
      .peek_data   (peek_data),
      .swap_valid  (swap_valid),
      .swap_ready  (swap_ready),
      .swap_addr_i (swap_addr_i),
      .swap_addr_j (swap_addr_j),
      .ks_valid    (ks_valid),
      .ks_data     (ks_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   typedef struct {
      logic [7:0] i;
      logic [7:0] j;
      logic [7:0] ks;
      logic [7:0] a;
      logic [7:0] exp_a;
      logic [7:0] b;
      logic [7:0] exp_b;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Wait for init_done, counting negedges since the last edge-aligned point.
   task automatic count_to_done(output int n);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         n++;
         if (init_done) break;
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      @(negedge clk);
      check("ready_before_swap", swap_ready, 1'b1);
      swap_valid  = 1'b1;
      swap_addr_i = v.i;
      swap_addr_j = v.j;
      @(negedge clk);                     // accept edge passed
      swap_valid = 1'b0;
      check("ks_valid_n1", ks_valid, 1'b0);
      peek_addr = v.a;
      rd_addr   = {8'd0, 8'd0, v.b, v.a};
      #1 check("peek_a", peek_data, v.exp_a);
      @(negedge clk);
      check("ks_valid_n2", ks_valid, 1'b1);
      check("ks_data_n2", ks_data, v.ks);
      check("rd_a", rd_data[7:0], v.exp_a);
      check("rd_b", rd_data[15:8], v.exp_b);
      peek_addr = v.b;
      #1 check("peek_b", peek_data, v.exp_b);
      @(negedge clk);
      check("ks_valid_drop", ks_valid, 1'b0);
      check("ks_data_hold", ks_data, v.ks);
      $display("vec %0d swap(%0d,%0d) ks=%0d S[%0d]=%0d S[%0d]=%0d",
               idx, v.i, v.j, ks_data, v.a, v.exp_a, v.b, v.exp_b);
   endtask

   initial begin
      int n;
      bit seen_ks;

      vecs[0] = '{8'd1,   8'd5,   8'd6,   8'd1,   8'd5,   8'd5,   8'd1};
      vecs[1] = '{8'd1,   8'd5,   8'd6,   8'd1,   8'd1,   8'd5,   8'd5};
      vecs[2] = '{8'd7,   8'd7,   8'd14,  8'd7,   8'd7,   8'd7,   8'd7};
      vecs[3] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd255, 8'd255, 8'd0};
      vecs[4] = '{8'd0,   8'd255, 8'd255, 8'd0,   8'd0,   8'd255, 8'd255};
      vecs[5] = '{8'd200, 8'd100, 8'd44,  8'd200, 8'd100, 8'd100, 8'd200};
      vecs[6] = '{8'd100, 8'd200, 8'd44,  8'd200, 8'd200, 8'd100, 8'd100};
      vecs[7] = '{8'd255, 8'd255, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255};
      vecs[8] = '{8'd3,   8'd128, 8'd131, 8'd3,   8'd128, 8'd128, 8'd3};
      vecs[9] = '{8'd128, 8'd3,   8'd131, 8'd3,   8'd3,   8'd128, 8'd128};

      rst_n       = 1'b0;
      init_start  = 1'b0;
      peek_addr   = 8'd0;
      swap_valid  = 1'b0;
      swap_addr_i = 8'd0;
      swap_addr_j = 8'd0;
      rd_addr     = 32'd0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_init_done", init_done, 1'b0);
      check("rst_swap_ready", swap_ready, 1'b0);
      check("rst_ks_valid", ks_valid, 1'b0);
      check("rst_ks_data", ks_data, 8'd0);
      check("rst_rd_data", rd_data, 32'd0);
      rst_n = 1'b1;

      count_to_done(n);
      check("fill_cycles", n, 256);
      $display("init_done after %0d cycles", n);

      rd_addr   = {8'd3, 8'd2, 8'd1, 8'd0};
      peek_addr = 8'd200;
      #1 check("peek_200", peek_data, 8'd200);
      @(negedge clk);
      check("rd0", rd_data[7:0],   8'd0);
      check("rd1", rd_data[15:8],  8'd1);
      check("rd2", rd_data[23:16], 8'd2);
      check("rd3", rd_data[31:24], 8'd3);
      $display("rd ports = %h", rd_data);

      // Table-driven single swaps; table leaves memory at identity.
      for (int k = 0; k < 10; k++) begin
         run_vec(k);
      end

      // Back-to-back swaps (1,2) then (2,3)
      @(negedge clk);
      swap_valid = 1'b1; swap_addr_i = 8'd1; swap_addr_j = 8'd2;
      @(negedge clk);
      check("b2b_ready", swap_ready, 1'b1);
      swap_addr_i = 8'd2; swap_addr_j = 8'd3;
      @(negedge clk);
      swap_valid = 1'b0;
      check("b2b_ks_valid0", ks_valid, 1'b1);
      check("b2b_ks_data0", ks_data, 8'd3);
      @(negedge clk);
      check("b2b_ks_valid1", ks_valid, 1'b1);
      check("b2b_ks_data1", ks_data, 8'd4);
      rd_addr = {8'd0, 8'd3, 8'd2, 8'd1};
      @(negedge clk);
      check("b2b_ks_drop", ks_valid, 1'b0);
      check("b2b_S1", rd_data[7:0],   8'd2);
      check("b2b_S2", rd_data[15:8],  8'd3);
      check("b2b_S3", rd_data[23:16], 8'd1);
      $display("b2b final S1=%0d S2=%0d S3=%0d", rd_data[7:0], rd_data[15:8], rd_data[23:16]);

      // init_start the cycle after a swap accept
      swap_valid = 1'b1; swap_addr_i = 8'd1; swap_addr_j = 8'd5;
      @(negedge clk);
      swap_valid = 1'b0;
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      n = 0;
      seen_ks = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (swap_ready) break;
         if (ks_valid) seen_ks = 1'b1;
         n++;
         @(negedge clk);
      end
      check("reinit_ready_low", n, 256);
      check("reinit_ks_squash", seen_ks, 1'b0);
      peek_addr = 8'd1;
      #1 check("reinit_S1", peek_data, 8'd1);
      peek_addr = 8'd5;
      #1 check("reinit_S5", peek_data, 8'd5);
      $display("reinit ready_low=%0d ks_seen=%0d", n, seen_ks);

      // Reset asserted at fill count 100
      rd_addr = {8'd3, 8'd2, 8'd1, 8'd5};
      @(negedge clk);
      init_start = 1'b1;
      @(negedge clk);
      init_start = 1'b0;
      repeat (100) @(negedge clk);
      check("midfill_rd_nonzero", (rd_data != 32'd0), 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_init_done", init_done, 1'b0);
      check("midrst_swap_ready", swap_ready, 1'b0);
      check("midrst_ks_valid", ks_valid, 1'b0);
      check("midrst_ks_data", ks_data, 8'd0);
      check("midrst_rd_data", rd_data, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_to_done(n);
      check("midrst_fill_cycles", n, 256);
      $display("after mid-fill reset init_done in %0d cycles", n);
      n = 0;
      for (int k = 0; k < 256; k++) begin
         peek_addr = 8'(k);
         #1;
         if (peek_data !== 8'(k)) n++;
      end
      check("identity_mismatches", n, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
